// File: rtl/imm_encoder_if.sv
// Stream interface for the I-type immediate encoder.
// Input beats, address load, and output beats toward the loader.
interface imm_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              valid_i;
    logic              ready_o;
    logic [31:0]       value_i;
    logic [2:0]        funct3_i;
    logic [4:0]        rs1_i;
    logic [4:0]        rd_i;
    logic              load_i;
    logic [ADDR_W-1:0] start_addr_i;
    logic              valid_o;
    logic              ready_i;
    logic [31:0]       instr_o;
    logic [ADDR_W-1:0] addr_o;
    logic              range_err_o;
    logic [7:0]        err_cnt_o;

    modport master (
        output valid_i, value_i, funct3_i, rs1_i, rd_i,
        output load_i, start_addr_i, ready_i,
        input  ready_o, valid_o, instr_o, addr_o,
        input  range_err_o, err_cnt_o
    );

    modport slave (
        input  valid_i, value_i, funct3_i, rs1_i, rd_i,
        input  load_i, start_addr_i, ready_i,
        output ready_o, valid_o, instr_o, addr_o,
        output range_err_o, err_cnt_o
    );
endinterface

// File: rtl/imm_encoder.sv
// Packs immediates into OP-IMM instructions with word addresses.
// IMM_ENCODER_SATURATE_EN: clamp out-of-range values instead of dropping.
module imm_encoder #(
    parameter int             ADDR_W = 8,
    parameter logic [6:0]     OPCODE = 7'b0010011
) (
    input logic        clk_i,
    input logic        rst_i,
    imm_encoder_if.slave bus
);
    logic              is_srai;
    logic              legal;
    logic [27:0]       hi_s;
    logic [20:0]       hi_a;
    logic [11:0]       imm;
    logic [31:0]       enc;

    logic              s1_full;
    logic              s1_err;
    logic [31:0]       s1_instr;
    logic              s2_full;
    logic [31:0]       instr_q;
    logic [ADDR_W-1:0] cnt;
    logic              err_q;
    logic [7:0]        err_cnt;

    logic              s1_move;
    logic              acc;
    logic              out_hs;

    assign is_srai = (bus.funct3_i == 3'b101);
    assign hi_s    = bus.value_i[31:4];
    assign hi_a    = bus.value_i[31:11];
    assign legal   = is_srai ? (&hi_s || ~|hi_s)
                             : (&hi_a || ~|hi_a);

    always_comb begin
        imm = is_srai ? {7'b0100000, bus.value_i[4:0]}
                      : bus.value_i[11:0];
`ifdef IMM_ENCODER_SATURATE_EN
        // Clamp toward the bound on the side of the value's sign
        if (!legal) begin
            if (is_srai)
                imm = {7'b0100000,
                       bus.value_i[31] ? 5'b10000 : 5'b01111};
            else
                imm = bus.value_i[31] ? 12'h800 : 12'h7FF;
        end
`endif
    end

    assign enc = {imm, bus.rs1_i, bus.funct3_i, bus.rd_i, OPCODE};

    assign out_hs  = s2_full && bus.ready_i;
    assign s1_move = s1_full && (!s2_full || bus.ready_i);
    assign bus.ready_o = !rst_i && (!s1_full || s1_move);
    assign acc     = bus.valid_i && bus.ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_full  <= 1'b0;
            s1_err   <= 1'b0;
            s1_instr <= '0;
            s2_full  <= 1'b0;
            instr_q  <= '0;
            cnt      <= '0;
            err_q    <= 1'b0;
            err_cnt  <= '0;
        end else begin
            if (acc) begin
                s1_full  <= 1'b1;
                s1_instr <= enc;
                s1_err   <= !legal;
            end else if (s1_move) begin
                s1_full  <= 1'b0;
            end

            if (s1_move) begin
`ifdef IMM_ENCODER_SATURATE_EN
                s2_full <= 1'b1;
                instr_q <= s1_instr;
`else
                s2_full <= !s1_err;
                if (!s1_err)
                    instr_q <= s1_instr;
`endif
            end else if (out_hs) begin
                s2_full <= 1'b0;
            end

            err_q <= s1_move && s1_err;
            if (s1_move && s1_err && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;

            // A load overrides the post-handshake increment
            if (bus.load_i)
                cnt <= bus.start_addr_i;
            else if (out_hs)
                cnt <= cnt + 1'b1;
        end
    end

    assign bus.valid_o     = s2_full;
    assign bus.instr_o     = instr_q;
    assign bus.addr_o      = cnt;
    assign bus.range_err_o = err_q;
    assign bus.err_cnt_o   = err_cnt;
endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: vector table plus
// backpressure, address, load-priority and reset sequences.
module tb_imm_encoder;
`ifdef IMM_ENCODER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [31:0] v;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rd;
        logic [31:0] instr;
        bit          err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_i;
    always #5 clk = ~clk;

    imm_encoder_if #(.ADDR_W(8)) bus ();

    imm_encoder #(.ADDR_W(8)) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    vec_t        vt[13];
    vec_t        sb[3];
    logic [31:0] oi[3];
    logic [7:0]  oa[3];

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t x);
        bus.value_i  = x.v;
        bus.funct3_i = x.f3;
        bus.rs1_i    = x.rs1;
        bus.rd_i     = x.rd;
    endtask

    task automatic run_stream(input int hold,
                              output int n_held,
                              output int rdy_low,
                              output int n_out);
        int  idx;
        bit  acc;
        idx     = 0;
        n_out   = 0;
        rdy_low = 0;
        n_held  = 0;
        for (int c = 0; c < hold + 15; c++) begin
            bus.ready_i = (c >= hold);
            bus.valid_i = (idx < 3);
            if (idx < 3) drive(sb[idx]);
            #1;
            if (c >= 2 && c < hold && !bus.ready_o) rdy_low++;
            if (c == hold) n_held = idx;
            if (bus.valid_o && bus.ready_i && n_out < 3) begin
                oi[n_out] = bus.instr_o;
                oa[n_out] = bus.addr_o;
                n_out++;
            end
            acc = bus.valid_i && bus.ready_o;
            step();
            if (acc) idx++;
        end
        bus.valid_i = 1'b0;
    endtask

    initial begin
        bit          got;
        bit          exp_out;
        int          pulses;
        int          lat;
        int          n_held;
        int          rdy_low;
        int          n_out;
        int          cnt_out;
        logic [31:0] gi;
        logic [7:0]  ga;
        logic [7:0]  exp_addr;
        logic [7:0]  exp_ecnt;

        vt[0]  = '{32'd5,        3'b000, 5'd0, 5'd1,
                   32'h00500093, 1'b0};
        vt[1]  = '{32'hFFFFFFFF, 3'b000, 5'd0, 5'd1,
                   32'hFFF00093, 1'b0};
        vt[2]  = '{32'd3,        3'b101, 5'd1, 5'd2,
                   32'h4030D113, 1'b0};
        vt[3]  = '{32'd2048,     3'b000, 5'd0, 5'd1,
                   32'h7FF00093, 1'b1};
        vt[4]  = '{32'd2047,     3'b000, 5'd2, 5'd3,
                   32'h7FF10193, 1'b0};
        vt[5]  = '{32'hFFFFF800, 3'b000, 5'd0, 5'd1,
                   32'h80000093, 1'b0};
        vt[6]  = '{32'hFFFFF7FF, 3'b000, 5'd0, 5'd1,
                   32'h80000093, 1'b1};
        vt[7]  = '{32'd15,       3'b101, 5'd1, 5'd2,
                   32'h40F0D113, 1'b0};
        vt[8]  = '{32'd16,       3'b101, 5'd1, 5'd2,
                   32'h40F0D113, 1'b1};
        vt[9]  = '{32'hFFFFFFF0, 3'b101, 5'd1, 5'd2,
                   32'h4100D113, 1'b0};
        vt[10] = '{32'hFFFFFFEF, 3'b101, 5'd1, 5'd2,
                   32'h4100D113, 1'b1};
        vt[11] = '{32'h00000123, 3'b111, 5'd5, 5'd6,
                   32'h1232F313, 1'b0};
        vt[12] = '{32'h80000000, 3'b000, 5'd0, 5'd1,
                   32'h80000093, 1'b1};

        sb[0] = '{32'd1, 3'b000, 5'd0, 5'd1, 32'h00100093, 1'b0};
        sb[1] = '{32'd2, 3'b000, 5'd0, 5'd2, 32'h00200113, 1'b0};
        sb[2] = '{32'd3, 3'b000, 5'd0, 5'd3, 32'h00300193, 1'b0};

        rst_i            = 1'b1;
        bus.valid_i      = 1'b0;
        bus.value_i      = '0;
        bus.funct3_i     = '0;
        bus.rs1_i        = '0;
        bus.rd_i         = '0;
        bus.load_i       = 1'b0;
        bus.start_addr_i = '0;
        bus.ready_i      = 1'b1;
        step(); step(); step();
        chk("rst_valid", {31'd0, bus.valid_o}, 32'd0);
        chk("rst_ready", {31'd0, bus.ready_o}, 32'd0);
        chk("rst_instr", bus.instr_o, 32'd0);
        chk("rst_addr", {24'd0, bus.addr_o}, 32'd0);
        chk("rst_err", {31'd0, bus.range_err_o}, 32'd0);
        chk("rst_ecnt", {24'd0, bus.err_cnt_o}, 32'd0);
        rst_i = 1'b0;
        step();

        exp_addr = 8'd0;
        exp_ecnt = 8'd0;
        foreach (vt[i]) begin
            drive(vt[i]);
            bus.valid_i = 1'b1;
            #1;
            chk($sformatf("v%0d_ready", i),
                {31'd0, bus.ready_o}, 32'd1);
            step();
            bus.valid_i = 1'b0;
            got    = 1'b0;
            pulses = 0;
            lat    = 0;
            gi     = '0;
            ga     = '0;
            for (int c = 1; c <= 5; c++) begin
                if (bus.valid_o && !got) begin
                    got = 1'b1;
                    gi  = bus.instr_o;
                    ga  = bus.addr_o;
                    lat = c;
                end
                if (bus.range_err_o) pulses++;
                step();
            end
            exp_out = !vt[i].err || SAT;
            chk($sformatf("v%0d_out", i),
                {31'd0, got}, {31'd0, exp_out});
            if (exp_out) begin
                chk($sformatf("v%0d_instr", i), gi, vt[i].instr);
                chk($sformatf("v%0d_addr", i),
                    {24'd0, ga}, {24'd0, exp_addr});
                chk($sformatf("v%0d_lat", i), lat, 2);
                exp_addr++;
            end
            chk($sformatf("v%0d_pulse", i), pulses,
                vt[i].err ? 1 : 0);
            if (vt[i].err) exp_ecnt++;
            chk($sformatf("v%0d_ecnt", i),
                {24'd0, bus.err_cnt_o}, {24'd0, exp_ecnt});
        end

        // Saturation of the error counter
        drive(vt[3]);
        bus.valid_i = 1'b1;
        for (int c = 0; c < 300; c++) step();
        bus.valid_i = 1'b0;
        step(); step(); step(); step();
        chk("ecnt_sat", {24'd0, bus.err_cnt_o}, 32'd255);

        // Backpressure: 3 beats offered with ready_i low
        bus.load_i       = 1'b1;
        bus.start_addr_i = 8'h10;
        step();
        bus.load_i = 1'b0;
        run_stream(4, n_held, rdy_low, n_out);
        chk("bp_held", n_held, 2);
        chk("bp_rdy_low", rdy_low, 2);
        chk("bp_nout", n_out, 3);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp_instr%0d", k), oi[k], sb[k].instr);
            chk($sformatf("bp_addr%0d", k),
                {24'd0, oa[k]}, 32'h10 + k);
        end

        // Address wrap after a load
        bus.load_i       = 1'b1;
        bus.start_addr_i = 8'hFE;
        step();
        bus.load_i = 1'b0;
        chk("ld_addr", {24'd0, bus.addr_o}, 32'hFE);
        run_stream(0, n_held, rdy_low, n_out);
        chk("wr_nout", n_out, 3);
        chk("wr_addr0", {24'd0, oa[0]}, 32'hFE);
        chk("wr_addr1", {24'd0, oa[1]}, 32'hFF);
        chk("wr_addr2", {24'd0, oa[2]}, 32'h00);

        // Load coinciding with an output handshake
        bus.ready_i = 1'b0;
        drive(sb[0]);
        bus.valid_i = 1'b1;
        step();
        drive(sb[1]);
        step();
        bus.valid_i = 1'b0;
        bus.ready_i      = 1'b1;
        bus.load_i       = 1'b1;
        bus.start_addr_i = 8'h40;
        #1;
        chk("lp_addr_a", {24'd0, bus.addr_o}, 32'h01);
        chk("lp_instr_a", bus.instr_o, sb[0].instr);
        step();
        bus.load_i = 1'b0;
        chk("lp_valid_b", {31'd0, bus.valid_o}, 32'd1);
        chk("lp_instr_b", bus.instr_o, sb[1].instr);
        chk("lp_addr_b", {24'd0, bus.addr_o}, 32'h40);
        step(); step();

        // Reset with two beats held
        bus.ready_i = 1'b0;
        drive(sb[0]);
        bus.valid_i = 1'b1;
        step();
        drive(sb[1]);
        step();
        bus.valid_i = 1'b0;
        chk("mr_pre_valid", {31'd0, bus.valid_o}, 32'd1);
        rst_i = 1'b1;
        #1;
        chk("mr_ready", {31'd0, bus.ready_o}, 32'd0);
        step();
        chk("mr_valid", {31'd0, bus.valid_o}, 32'd0);
        chk("mr_ecnt", {24'd0, bus.err_cnt_o}, 32'd0);
        chk("mr_addr", {24'd0, bus.addr_o}, 32'd0);
        chk("mr_instr", bus.instr_o, 32'd0);
        rst_i       = 1'b0;
        bus.ready_i = 1'b1;
        cnt_out     = 0;
        for (int c = 0; c < 5; c++) begin
            if (bus.valid_o) cnt_out++;
            step();
        end
        chk("mr_flushed", cnt_out, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
